// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Multi-cycle instruction sequencer for the 16-bit CPU. It walks each
// instruction through fetch -> decode -> execute -> writeback and drives the
// datapath strobes for the PC, instruction register, ALU, register file,
// immediate bus driver and data memory. Memory accesses wait for a
// handshake, and a bus timeout turns a stalled access into a terminal fault.
//
// Every output is a register loaded from the decode of the next state and
// next latched fields. The strobes therefore change only on the clock edge
// that enters a state, and async reset clears them immediately.
//
// Parameters
//   MEM_TIMEOUT   cycles to wait for mem_ready_i in FETCH/MEM before faulting (1..255)
//
// Ports
//   clk_i           system clock, all state on the rising edge
//   rst_n_i         asynchronous active-low reset
//   instr_i[15:0]   instruction register output: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
//   mem_ready_i     the current memory access completes this cycle
//   zero_flag_i     ALU zero flag (used by JZ)
//   carry_flag_i    ALU carry flag (used by JC)
//   mem_rd_o        memory read request (instruction fetch or LD)
//   mem_wr_o        memory write request (ST)
//   d_addr_o[7:0]   data memory address, the latched imm while in MEM, else 0
//   ir_ld_o         load the instruction register from the bus
//   pc_inc_o        increment PC
//   pc_ld_o         load PC from the bus (jump)
//   imm_oe_o        drive the zero-extended imm onto the bus
//   alu_en_o        ALU compute strobe
//   alu_op_o[2:0]   ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
//   alu_oe_o        drive the ALU result onto the bus
//   reg_sel_in_o    register file write select
//   reg_sel_out_o   register file read select
//   reg_we_o        register file write enable
//   reg_oe_o        register file output enable onto the data bus
//   illegal_o       one-cycle pulse for an undefined opcode
//   halted_o        sticky: HLT executed or bus fault
//   bus_err_o       sticky: memory timeout
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | one cycle after reset release
// FETCH   | instruction read; waits for mem_ready, counts toward timeout
// LOADIR  | load IR and increment PC
// DECODE  | latch op/rd/rs/imm from the IR
// EXEC    | ALU, LDI, jump and NOP/illegal work
// MEM     | LD/ST data access; waits for mem_ready, counts toward timeout
// WB      | register file write of the ALU result or the loaded data
// HALT    | HLT executed; terminal until reset
// FAULT   | memory timeout; terminal until reset
// ---------------------------------------------------------------------------
module control_unit #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] instr_i,
    input  logic        mem_ready_i,
    input  logic        zero_flag_i,
    input  logic        carry_flag_i,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic [7:0]  d_addr_o,
    output logic        ir_ld_o,
    output logic        pc_inc_o,
    output logic        pc_ld_o,
    output logic        imm_oe_o,
    output logic        alu_en_o,
    output logic [2:0]  alu_op_o,
    output logic        alu_oe_o,
    output logic [1:0]  reg_sel_in_o,
    output logic [1:0]  reg_sel_out_o,
    output logic        reg_we_o,
    output logic        reg_oe_o,
    output logic        illegal_o,
    output logic        halted_o,
    output logic        bus_err_o
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOADIR,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT,
        ST_FAULT
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_LD  = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    // The counter holds the number of wait cycles already spent in the
    // access, so the cycle that sees this value without ready is the
    // MEM_TIMEOUT-th one and is the last chance before faulting.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    function automatic logic is_alu(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h5);
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  rd_q, rd_d;
    logic [1:0]  rs_q, rs_d;
    logic [7:0]  imm_q, imm_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic [7:0]  d_addr_q, d_addr_d;
    logic        ir_ld_q, ir_ld_d;
    logic        pc_inc_q, pc_inc_d;
    logic        pc_ld_q, pc_ld_d;
    logic        imm_oe_q, imm_oe_d;
    logic        alu_en_q, alu_en_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic        alu_oe_q, alu_oe_d;
    logic [1:0]  reg_sel_in_q, reg_sel_in_d;
    logic [1:0]  reg_sel_out_q, reg_sel_out_d;
    logic        reg_we_q, reg_we_d;
    logic        reg_oe_q, reg_oe_d;
    logic        illegal_q, illegal_d;
    logic        halted_q, halted_d;
    logic        bus_err_q, bus_err_d;

    // Next state, latched fields and timeout counter.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs_d    = rs_q;
        imm_d   = imm_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                cnt_d   = 8'd0;
            end
            ST_FETCH: begin
                if (mem_ready_i) begin
                    state_d = ST_LOADIR;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_LOADIR: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                op_d  = instr_i[15:12];
                rd_d  = instr_i[11:10];
                rs_d  = instr_i[9:8];
                imm_d = instr_i[7:0];
                if (instr_i[15:12] == OP_HLT) begin
                    state_d = ST_HALT;
                end else if ((instr_i[15:12] == OP_LD) || (instr_i[15:12] == OP_ST)) begin
                    state_d = ST_MEM;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_alu(op_q)) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                    cnt_d   = 8'd0;
                end
            end
            ST_MEM: begin
                if (mem_ready_i) begin
                    if (op_q == OP_LD) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                        cnt_d   = 8'd0;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                cnt_d   = 8'd0;
            end
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode of the state being entered. The jump condition for JZ/JC
    // is taken from the flags presented on the edge that enters EXEC.
    always_comb begin
        mem_rd_d      = 1'b0;
        mem_wr_d      = 1'b0;
        d_addr_d      = 8'd0;
        ir_ld_d       = 1'b0;
        pc_inc_d      = 1'b0;
        pc_ld_d       = 1'b0;
        imm_oe_d      = 1'b0;
        alu_en_d      = 1'b0;
        alu_op_d      = 3'd0;
        alu_oe_d      = 1'b0;
        reg_sel_in_d  = 2'd0;
        reg_sel_out_d = 2'd0;
        reg_we_d      = 1'b0;
        reg_oe_d      = 1'b0;
        illegal_d     = 1'b0;
        halted_d      = 1'b0;
        bus_err_d     = 1'b0;

        case (state_d)
            ST_FETCH: begin
                mem_rd_d = 1'b1;
            end
            ST_LOADIR: begin
                ir_ld_d  = 1'b1;
                pc_inc_d = 1'b1;
            end
            ST_EXEC: begin
                case (op_d)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                        alu_en_d      = 1'b1;
                        alu_op_d      = op_d[2:0] - 3'd1;
                        reg_sel_out_d = rs_d;
                        reg_oe_d      = 1'b1;
                    end
                    OP_LDI: begin
                        imm_oe_d     = 1'b1;
                        reg_sel_in_d = rd_d;
                        reg_we_d     = 1'b1;
                    end
                    OP_JMP: begin
                        imm_oe_d = 1'b1;
                        pc_ld_d  = 1'b1;
                    end
                    OP_JZ: begin
                        imm_oe_d = 1'b1;
                        pc_ld_d  = zero_flag_i;
                    end
                    OP_JC: begin
                        imm_oe_d = 1'b1;
                        pc_ld_d  = carry_flag_i;
                    end
                    4'hC, 4'hD, 4'hE: begin
                        illegal_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                d_addr_d = imm_d;
                if (op_d == OP_LD) begin
                    mem_rd_d = 1'b1;
                end else begin
                    mem_wr_d      = 1'b1;
                    reg_sel_out_d = rs_d;
                    reg_oe_d      = 1'b1;
                end
            end
            ST_WB: begin
                reg_sel_in_d = rd_d;
                reg_we_d     = 1'b1;
                alu_oe_d     = is_alu(op_d);
            end
            ST_HALT: begin
                halted_d = 1'b1;
            end
            ST_FAULT: begin
                halted_d  = 1'b1;
                bus_err_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            op_q          <= 4'd0;
            rd_q          <= 2'd0;
            rs_q          <= 2'd0;
            imm_q         <= 8'd0;
            cnt_q         <= 8'd0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            d_addr_q      <= 8'd0;
            ir_ld_q       <= 1'b0;
            pc_inc_q      <= 1'b0;
            pc_ld_q       <= 1'b0;
            imm_oe_q      <= 1'b0;
            alu_en_q      <= 1'b0;
            alu_op_q      <= 3'd0;
            alu_oe_q      <= 1'b0;
            reg_sel_in_q  <= 2'd0;
            reg_sel_out_q <= 2'd0;
            reg_we_q      <= 1'b0;
            reg_oe_q      <= 1'b0;
            illegal_q     <= 1'b0;
            halted_q      <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            rs_q          <= rs_d;
            imm_q         <= imm_d;
            cnt_q         <= cnt_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            d_addr_q      <= d_addr_d;
            ir_ld_q       <= ir_ld_d;
            pc_inc_q      <= pc_inc_d;
            pc_ld_q       <= pc_ld_d;
            imm_oe_q      <= imm_oe_d;
            alu_en_q      <= alu_en_d;
            alu_op_q      <= alu_op_d;
            alu_oe_q      <= alu_oe_d;
            reg_sel_in_q  <= reg_sel_in_d;
            reg_sel_out_q <= reg_sel_out_d;
            reg_we_q      <= reg_we_d;
            reg_oe_q      <= reg_oe_d;
            illegal_q     <= illegal_d;
            halted_q      <= halted_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign mem_rd_o      = mem_rd_q;
    assign mem_wr_o      = mem_wr_q;
    assign d_addr_o      = d_addr_q;
    assign ir_ld_o       = ir_ld_q;
    assign pc_inc_o      = pc_inc_q;
    assign pc_ld_o       = pc_ld_q;
    assign imm_oe_o      = imm_oe_q;
    assign alu_en_o      = alu_en_q;
    assign alu_op_o      = alu_op_q;
    assign alu_oe_o      = alu_oe_q;
    assign reg_sel_in_o  = reg_sel_in_q;
    assign reg_sel_out_o = reg_sel_out_q;
    assign reg_we_o      = reg_we_q;
    assign reg_oe_o      = reg_oe_q;
    assign illegal_o     = illegal_q;
    assign halted_o      = halted_q;
    assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//
// Each instruction is turned into a list of per-cycle expected strobe
// vectors by a phase-level model: a memory access of w wait states is w+1
// cycles of the same strobes (capped at the timeout, then fault), followed
// by the fixed LOADIR/DECODE/EXEC/WB cycles that the opcode needs. Inputs the
// design must ignore are randomised in every cycle where they do not matter.
// ---------------------------------------------------------------------------
module tb_control_unit;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        mem_ready = 1'b0;
    logic        zero_flag = 1'b0;
    logic        carry_flag = 1'b0;
    logic        mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, imm_oe, alu_en, alu_oe;
    logic        reg_we, reg_oe, illegal, halted, bus_err;
    logic [7:0]  d_addr;
    logic [2:0]  alu_op;
    logic [1:0]  reg_sel_in, reg_sel_out;

    always #5 clk = ~clk;

    control_unit #(.MEM_TIMEOUT(T)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .instr_i       (instr),
        .mem_ready_i   (mem_ready),
        .zero_flag_i   (zero_flag),
        .carry_flag_i  (carry_flag),
        .mem_rd_o      (mem_rd),
        .mem_wr_o      (mem_wr),
        .d_addr_o      (d_addr),
        .ir_ld_o       (ir_ld),
        .pc_inc_o      (pc_inc),
        .pc_ld_o       (pc_ld),
        .imm_oe_o      (imm_oe),
        .alu_en_o      (alu_en),
        .alu_op_o      (alu_op),
        .alu_oe_o      (alu_oe),
        .reg_sel_in_o  (reg_sel_in),
        .reg_sel_out_o (reg_sel_out),
        .reg_we_o      (reg_we),
        .reg_oe_o      (reg_oe),
        .illegal_o     (illegal),
        .halted_o      (halted),
        .bus_err_o     (bus_err)
    );

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic [7:0] d_addr;
        logic       ir_ld;
        logic       pc_inc;
        logic       pc_ld;
        logic       imm_oe;
        logic       alu_en;
        logic [2:0] alu_op;
        logic       alu_oe;
        logic [1:0] reg_sel_in;
        logic [1:0] reg_sel_out;
        logic       reg_we;
        logic       reg_oe;
        logic       illegal;
        logic       halted;
        logic       bus_err;
    } outs_t;

    typedef struct {
        outs_t       exp;
        logic        rdy;
        logic [15:0] ins;
        logic        zf;
        logic        cf;
    } step_t;

    outs_t obs;
    assign obs = {mem_rd, mem_wr, d_addr, ir_ld, pc_inc, pc_ld, imm_oe, alu_en, alu_op,
                  alu_oe, reg_sel_in, reg_sel_out, reg_we, reg_oe, illegal, halted, bus_err};

    step_t steps[$];
    int    n_vec = 0;
    int    n_err = 0;
    bit    aligned = 1'b0;

    // A cycle whose inputs are don't-care: everything random.
    function automatic step_t mk(input outs_t e);
        step_t s;
        s.exp = e;
        s.rdy = 1'($urandom_range(0, 1));
        s.ins = 16'($urandom);
        s.zf  = 1'($urandom_range(0, 1));
        s.cf  = 1'($urandom_range(0, 1));
        return s;
    endfunction

    task automatic push_term(input outs_t e, input int n);
        for (int k = 0; k < n; k++) steps.push_back(mk(e));
    endtask

    task automatic push_access(input outs_t e, input int w, output bit faulted);
        int    n;
        step_t s;
        outs_t f;
        n = (w < T) ? w + 1 : T;
        for (int k = 0; k < n; k++) begin
            s = mk(e);
            s.rdy = (w < T) && (k == n - 1);
            steps.push_back(s);
        end
        faulted = (w >= T);
        if (faulted) begin
            f = '0;
            f.halted  = 1'b1;
            f.bus_err = 1'b1;
            push_term(f, 4);
        end
    endtask

    // Appends the expected cycles of one instruction, starting at FETCH.
    task automatic model_instr(input logic [15:0] ins, input int wf, input int wm,
                               input logic zf, input logic cf, output bit term);
        outs_t      e;
        step_t      s;
        bit         f;
        logic [3:0] op;
        logic [1:0] rd, rs;
        logic [7:0] imm;
        op  = ins[15:12];
        rd  = ins[11:10];
        rs  = ins[9:8];
        imm = ins[7:0];
        term = 1'b0;

        e = '0;
        e.mem_rd = 1'b1;
        push_access(e, wf, f);
        if (f) begin
            term = 1'b1;
            return;
        end
        e = '0;
        e.ir_ld  = 1'b1;
        e.pc_inc = 1'b1;
        steps.push_back(mk(e));
        e = '0;
        s = mk(e);
        s.ins = ins;
        s.zf  = zf;
        s.cf  = cf;
        steps.push_back(s);

        if (op == 4'hF) begin
            e = '0;
            e.halted = 1'b1;
            push_term(e, 4);
            term = 1'b1;
            return;
        end
        if (op == 4'h7 || op == 4'h8) begin
            e = '0;
            e.d_addr = imm;
            if (op == 4'h7) begin
                e.mem_rd = 1'b1;
            end else begin
                e.mem_wr      = 1'b1;
                e.reg_sel_out = rs;
                e.reg_oe      = 1'b1;
            end
            push_access(e, wm, f);
            if (f) begin
                term = 1'b1;
                return;
            end
            if (op == 4'h7) begin
                e = '0;
                e.reg_sel_in = rd;
                e.reg_we     = 1'b1;
                steps.push_back(mk(e));
            end
            return;
        end

        e = '0;
        if (op >= 4'h1 && op <= 4'h5) begin
            e.alu_en      = 1'b1;
            e.alu_op      = 3'(op - 4'd1);
            e.reg_sel_out = rs;
            e.reg_oe      = 1'b1;
        end else if (op == 4'h6) begin
            e.imm_oe     = 1'b1;
            e.reg_sel_in = rd;
            e.reg_we     = 1'b1;
        end else if (op == 4'h9) begin
            e.imm_oe = 1'b1;
            e.pc_ld  = 1'b1;
        end else if (op == 4'hA) begin
            e.imm_oe = 1'b1;
            e.pc_ld  = zf;
        end else if (op == 4'hB) begin
            e.imm_oe = 1'b1;
            e.pc_ld  = cf;
        end else if (op >= 4'hC) begin
            e.illegal = 1'b1;
        end
        s = mk(e);
        s.zf = zf;
        s.cf = cf;
        steps.push_back(s);
        if (op >= 4'h1 && op <= 4'h5) begin
            e = '0;
            e.alu_oe     = 1'b1;
            e.reg_sel_in = rd;
            e.reg_we     = 1'b1;
            steps.push_back(mk(e));
        end
    endtask

    // Moves to the next cycle (unless already at its start), drives its
    // inputs and hands back what the outputs must be during it.
    task automatic apply_next(output outs_t e);
        step_t s;
        s = steps.pop_front();
        if (aligned) aligned = 1'b0;
        else begin
            @(posedge clk);
            #1;
        end
        mem_ready  = s.rdy;
        instr      = s.ins;
        zero_flag  = s.zf;
        carry_flag = s.cf;
        e = s.exp;
    endtask

    // Holds reset for two edges, releases it just after an edge so a full
    // IDLE cycle follows, and queues that IDLE cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        steps.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        aligned = 1'b1;
        steps.push_back(mk('0));
    endtask

    task automatic test_reset();
        outs_t e;
        bit    t;
        int    cyc;
        #1 rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            instr = 16'($urandom);
            mem_ready = 1'b1;
            n_vec++;
            if (obs !== outs_t'('0)) begin
                n_err++;
                $display("FAIL reset_hold cycle %0d: got %h expected %h", k, obs, outs_t'('0));
            end
        end
        do_reset();
        model_instr(16'h0000, 0, 0, 1'b0, 1'b0, t);
        cyc = 0;
        while (steps.size() > 0) begin
            apply_next(e);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reset_release cycle %0d: got %h expected %h", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_ldi();
        outs_t e;
        bit    t;
        int    cyc;
        do_reset();
        model_instr(16'h6A55, 0, 0, 1'b0, 1'b0, t);
        model_instr(16'h0000, 0, 0, 1'b0, 1'b0, t);
        cyc = 0;
        while (steps.size() > 0) begin
            apply_next(e);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL ldi cycle %0d: got %h expected %h", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_alu_wait();
        outs_t e;
        bit    t;
        int    cyc;
        do_reset();
        model_instr(16'h1600, 3, 0, 1'b0, 1'b0, t);
        model_instr(16'h5B00, 0, 0, 1'b0, 1'b0, t);
        model_instr(16'h0000, 1, 0, 1'b0, 1'b0, t);
        cyc = 0;
        while (steps.size() > 0) begin
            apply_next(e);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL alu_wait cycle %0d: got %h expected %h", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_jcc();
        outs_t e;
        bit    t;
        int    cyc;
        do_reset();
        model_instr(16'hA040, 0, 0, 1'b0, 1'b1, t);
        model_instr(16'hA040, 0, 0, 1'b1, 1'b0, t);
        model_instr(16'hB0C3, 2, 0, 1'b1, 1'b0, t);
        model_instr(16'hB0C3, 0, 0, 1'b0, 1'b1, t);
        model_instr(16'h9012, 0, 0, 1'b0, 1'b0, t);
        cyc = 0;
        while (steps.size() > 0) begin
            apply_next(e);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL jcc cycle %0d: got %h expected %h", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_st_timeout();
        outs_t e;
        bit    t;
        int    cyc;
        do_reset();
        model_instr(16'h7DA1, 0, T - 1, 1'b0, 1'b0, t);
        model_instr(16'h8130, 0, 1000, 1'b0, 1'b0, t);
        cyc = 0;
        while (steps.size() > 0) begin
            apply_next(e);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL st_timeout cycle %0d: got %h expected %h", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_illegal_halt();
        outs_t e;
        bit    t;
        int    cyc;
        do_reset();
        model_instr(16'hC000, 0, 0, 1'b0, 1'b0, t);
        model_instr(16'hD0FF, 0, 0, 1'b0, 1'b0, t);
        model_instr(16'hE123, 0, 0, 1'b0, 1'b0, t);
        model_instr(16'hF000, 0, 0, 1'b0, 1'b0, t);
        cyc = 0;
        while (steps.size() > 0) begin
            apply_next(e);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL illegal_halt cycle %0d: got %h expected %h", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_reset_mid_mem();
        outs_t e;
        bit    t;
        int    cyc;
        do_reset();
        model_instr(16'h7255, 0, 8, 1'b0, 1'b0, t);
        // IDLE, FETCH, LOADIR, DECODE, then four wait cycles of the LD access
        for (cyc = 0; cyc < 8; cyc++) begin
            apply_next(e);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reset_mid_mem cycle %0d: got %h expected %h", cyc, obs, e);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== outs_t'('0)) begin
            n_err++;
            $display("FAIL reset_async: got %h expected %h", obs, outs_t'('0));
        end
        do_reset();
        model_instr(16'h4E00, 0, 0, 1'b0, 1'b0, t);
        cyc = 0;
        while (steps.size() > 0) begin
            apply_next(e);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reset_restart cycle %0d: got %h expected %h", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_random();
        outs_t       e;
        bit          t;
        int          cyc;
        int          wf, wm;
        logic [15:0] ins;
        do_reset();
        cyc = 0;
        for (int n = 0; n < 80; n++) begin
            ins = 16'($urandom);
            wf  = ($urandom_range(0, 29) == 0) ? T + 2 : int'($urandom_range(0, 4));
            wm  = ($urandom_range(0, 9) == 0) ? T : int'($urandom_range(0, 5));
            model_instr(ins, wf, wm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
            while (steps.size() > 0) begin
                apply_next(e);
                n_vec++;
                if (obs !== e) begin
                    n_err++;
                    $display("FAIL random instr %h cycle %0d: got %h expected %h", ins, cyc, obs, e);
                end
                cyc++;
            end
            if (t) do_reset();
        end
        while (steps.size() > 0) begin
            apply_next(e);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL random tail cycle %0d: got %h expected %h", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_alu_wait();
        test_jcc();
        test_st_timeout();
        test_illegal_halt();
        test_reset_mid_mem();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
